// File: rtl/avalon_sdram_tester.sv
// Avalon-MM bring-up master: writes an address-derived pattern over a word range,
// reads it back with pipelined reads and reports error count and first failing address.
module avalon_sdram_tester #(
  parameter int              AW              = 24,
  parameter int              DW              = 16,
  parameter int              BYTE            = 2,
  parameter logic [DW-1:0]   SEED            = DW'(16'hA5C3),
  parameter int              MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   cfg_base,
  input  logic [AW-1:0]   cfg_len,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     err_count,
  output logic [AW-1:0]   first_err_addr,
  output logic            avm_read,
  output logic            avm_write,
  output logic [AW-1:0]   avm_address,
  output logic [DW-1:0]   avm_writedata,
  output logic [BYTE-1:0] avm_byteenable,
  input  logic [DW-1:0]   avm_readdata,
  input  logic            avm_waitrequest,
  input  logic            avm_readdatavalid
);
  localparam int              OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]   OMAX = OW'(MAX_OUTSTANDING);
  localparam int              EW   = (AW > DW) ? AW : DW;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d, len_q, len_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, chk_idx_q, chk_idx_d;
  logic [AW-1:0] first_q, first_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [15:0]   err_q, err_d;
  logic          seen_q, seen_d;

  logic start_ok, wr_acc, rd_acc, rsp, spurious, chk_hit, mismatch;
  logic [AW-1:0] chk_addr;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    logic [EW-1:0] ax;
    ax = EW'(a);
    return ax[DW-1:0] ^ SEED;
  endfunction

  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
  assign wr_acc   = avm_write && !avm_waitrequest;
  assign rd_acc   = avm_read && !avm_waitrequest;
  // Responses outside a running test (e.g. stragglers after reset) are dropped.
  assign rsp      = avm_readdatavalid && busy;
  assign spurious = rsp && (outst_q == '0);
  assign chk_hit  = rsp && (outst_q != '0);
  assign chk_addr = base_q + chk_idx_q;
  assign mismatch = chk_hit && (avm_readdata != pattern(chk_addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      chk_idx_q <= '0;
      first_q   <= '0;
      outst_q   <= '0;
      err_q     <= '0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      chk_idx_q <= chk_idx_d;
      first_q   <= first_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
      seen_q    <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = (cfg_len != '0) ? S_WRITE : S_DONE;
      S_WRITE: if (wr_acc && wr_idx_q == len_q - AW'(1)) state_d = S_READ;
      S_READ:  if (rd_acc && rd_idx_q == len_q - AW'(1)) state_d = S_DRAIN;
      S_DRAIN: if (chk_idx_q == len_q && outst_q == '0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_WRITE: begin
        avm_write     = 1'b1;
        avm_address   = base_q + wr_idx_q;
        avm_writedata = pattern(base_q + wr_idx_q);
        busy          = 1'b1;
      end
      S_READ: begin
        // A response landing at the limit frees a slot in the same cycle.
        avm_read    = (rd_idx_q < len_q) && ((outst_q < OMAX) || avm_readdatavalid);
        avm_address = base_q + rd_idx_q;
        busy        = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    base_d    = base_q;
    len_d     = len_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    chk_idx_d = chk_idx_q;
    first_d   = first_q;
    outst_d   = outst_q;
    err_d     = err_q;
    seen_d    = seen_q;
    if (start_ok) begin
      base_d    = cfg_base;
      len_d     = cfg_len;
      wr_idx_d  = '0;
      rd_idx_d  = '0;
      chk_idx_d = '0;
      first_d   = '0;
      outst_d   = '0;
      err_d     = '0;
      seen_d    = 1'b0;
    end else begin
      if (wr_acc) wr_idx_d = wr_idx_q + AW'(1);
      if (rd_acc) rd_idx_d = rd_idx_q + AW'(1);
      if (rd_acc && !chk_hit)      outst_d = outst_q + OW'(1);
      else if (!rd_acc && chk_hit) outst_d = outst_q - OW'(1);
      if (chk_hit) chk_idx_d = chk_idx_q + AW'(1);
      if ((mismatch || spurious) && err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (mismatch && !seen_q) begin
        first_d = chk_addr;
        seen_d  = 1'b1;
      end
    end
  end

  assign pass           = done && (err_q == '0);
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign avm_byteenable = '1;

endmodule

// File: tb/tb_avalon_sdram_tester.sv
// Bench for avalon_sdram_tester: SDRAM slave model with latency/stall/corruption knobs,
// write-side scoreboard and bus-protocol monitor.
module tb_avalon_sdram_tester;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [23:0] cfg_base, cfg_len;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [23:0] first_err_addr;
  logic        avm_read, avm_write;
  logic [23:0] avm_address;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic [15:0] avm_readdata;
  logic        avm_waitrequest, avm_readdatavalid;

  avalon_sdram_tester dut (
    .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .avm_read(avm_read), .avm_write(avm_write),
    .avm_address(avm_address), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // slave knobs
  int          lat = 3;
  bit          rand_wait = 0;
  bit          corrupt_en = 0;
  logic [23:0] corrupt_addr = '0;
  int          spur_req = 0;
  int          spur_done = 0;

  typedef struct { logic [23:0] addr; int due; } rd_t;
  typedef struct { logic [23:0] addr; logic [15:0] data; } wr_t;
  rd_t         rq[$];
  wr_t         exp_wr[$];
  logic [15:0] mem [logic [23:0]];
  int          cyc = 0;

  always @(posedge clk) begin
    rd_t         r;
    logic [15:0] d;
    if (reset) begin
      rq.delete();
      avm_waitrequest   <= 1'b0;
      avm_readdatavalid <= 1'b0;
      avm_readdata      <= '0;
      spur_done = spur_req;
      cyc = 0;
    end else begin
      cyc++;
      if (avm_write && !avm_waitrequest) mem[avm_address] = avm_writedata;
      if (avm_read && !avm_waitrequest) begin
        r.addr = avm_address;
        r.due  = cyc + lat;
        rq.push_back(r);
      end
      avm_readdatavalid <= 1'b0;
      if (rq.size() != 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        d = mem.exists(r.addr) ? mem[r.addr] : 16'h0000;
        if (corrupt_en && r.addr == corrupt_addr) d = d ^ 16'h0010;
        avm_readdatavalid <= 1'b1;
        avm_readdata      <= d;
      end else if (spur_req != spur_done) begin
        spur_done++;
        avm_readdatavalid <= 1'b1;
        avm_readdata      <= 16'hBEEF;
      end
      avm_waitrequest <= rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Bus monitor: sampled on the falling edge, i.e. the values the next rising edge will see.
  int          out_mon, peak, stall_viol, both_viol, full_viol, rw_seen, rd_cnt;
  bit          prev_stall;
  logic        p_rd, p_wr;
  logic [23:0] p_addr;
  logic [15:0] p_data;

  always @(negedge clk) begin
    wr_t e;
    bit  racc;
    if (reset) begin
      out_mon = 0; peak = 0; stall_viol = 0; both_viol = 0; full_viol = 0;
      rw_seen = 0; rd_cnt = 0; prev_stall = 0;
    end else begin
      if (avm_read || avm_write) rw_seen++;
      if (avm_read && avm_write) both_viol++;
      if (prev_stall && (avm_read !== p_rd || avm_write !== p_wr || avm_address !== p_addr ||
                         (p_wr && avm_writedata !== p_data))) stall_viol++;
      if (out_mon == MAXO && avm_read && !avm_readdatavalid) full_viol++;
      if (avm_write && !avm_waitrequest) begin
        vectors++;
        if (exp_wr.size() == 0) begin
          miscompares++;
          $display("FAIL write_unexpected: addr %h data %h, required no write", avm_address, avm_writedata);
        end else begin
          e = exp_wr.pop_front();
          if (avm_address !== e.addr || avm_writedata !== e.data) begin
            miscompares++;
            $display("FAIL write_data: got %h/%h, required %h/%h", avm_address, avm_writedata, e.addr, e.data);
          end
        end
      end
      racc = avm_read && !avm_waitrequest;
      if (racc) rd_cnt++;
      if (racc && !(avm_readdatavalid && out_mon != 0)) out_mon++;
      else if (!racc && avm_readdatavalid && out_mon != 0) out_mon--;
      if (out_mon > peak) peak = out_mon;
      prev_stall = (avm_read || avm_write) && avm_waitrequest;
      p_rd = avm_read; p_wr = avm_write; p_addr = avm_address; p_data = avm_writedata;
    end
  end

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0;
    lat = 3; rand_wait = 0; corrupt_en = 0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic start_run(input logic [23:0] b, input logic [23:0] n);
    wr_t e;
    @(negedge clk); #1;
    cfg_base = b; cfg_len = n; start = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      e.addr = b + 24'(i);
      e.data = e.addr[15:0] ^ 16'hA5C3;
      exp_wr.push_back(e);
    end
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); #1;
      if (done) ok = 1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    reset = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({busy, done, pass, avm_read, avm_write} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctl: busy/done/pass/rd/wr=%b, required 00000", {busy, done, pass, avm_read, avm_write});
    end
    vectors++;
    if (err_count !== 16'h0 || first_err_addr !== 24'h0) begin
      miscompares++; $display("FAIL reset_err: err=%h first=%h, required 0/0", err_count, first_err_addr);
    end
    vectors++;
    if (avm_address !== 24'h0 || avm_writedata !== 16'h0) begin
      miscompares++; $display("FAIL reset_bus: addr=%h data=%h, required 0/0", avm_address, avm_writedata);
    end
    vectors++;
    if (avm_byteenable !== 2'b11) begin
      miscompares++; $display("FAIL reset_be: got %b, required 11", avm_byteenable);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    start_run(24'h100, 24'd8);
    wait_done(ok);
    vectors++;
    if (!ok || pass !== 1'b1 || err_count !== 16'h0) begin
      miscompares++; $display("FAIL basic_result: done=%b pass=%b err=%0d, required 1/1/0", ok, pass, err_count);
    end
    vectors++;
    if (rd_cnt != 8 || exp_wr.size() != 0) begin
      miscompares++; $display("FAIL basic_counts: reads=%0d pending_writes=%0d, required 8/0", rd_cnt, exp_wr.size());
    end
    vectors++;
    if (busy !== 1'b0 || both_viol != 0) begin
      miscompares++; $display("FAIL basic_busy: busy=%b rd&wr=%0d, required 0/0", busy, both_viol);
    end
  endtask

  task automatic test_waitrequest();
    bit ok;
    do_reset();
    rand_wait = 1;
    start_run(24'h100, 24'd8);
    wait_done(ok);
    vectors++;
    if (!ok || pass !== 1'b1 || err_count !== 16'h0) begin
      miscompares++; $display("FAIL stall_result: done=%b pass=%b err=%0d, required 1/1/0", ok, pass, err_count);
    end
    vectors++;
    if (stall_viol != 0 || both_viol != 0) begin
      miscompares++; $display("FAIL stall_stable: unstable=%0d rd&wr=%0d, required 0/0", stall_viol, both_viol);
    end
    vectors++;
    if (rd_cnt != 8 || exp_wr.size() != 0) begin
      miscompares++; $display("FAIL stall_counts: reads=%0d pending_writes=%0d, required 8/0", rd_cnt, exp_wr.size());
    end
  endtask

  task automatic test_corrupt();
    bit ok;
    do_reset();
    corrupt_en = 1; corrupt_addr = 24'h103;
    start_run(24'h100, 24'd8);
    wait_done(ok);
    vectors++;
    if (!ok || pass !== 1'b0 || err_count !== 16'd1) begin
      miscompares++; $display("FAIL corrupt_result: done=%b pass=%b err=%0d, required 1/0/1", ok, pass, err_count);
    end
    vectors++;
    if (first_err_addr !== 24'h103) begin
      miscompares++; $display("FAIL corrupt_addr: got %h, required 000103", first_err_addr);
    end
  endtask

  task automatic test_latency();
    bit ok;
    do_reset();
    lat = 10;
    start_run(24'h040, 24'd8);
    wait_done(ok);
    vectors++;
    if (!ok || pass !== 1'b1 || err_count !== 16'h0) begin
      miscompares++; $display("FAIL latency_result: done=%b pass=%b err=%0d, required 1/1/0", ok, pass, err_count);
    end
    vectors++;
    if (peak != MAXO) begin
      miscompares++; $display("FAIL latency_peak: got %0d, required %0d", peak, MAXO);
    end
    vectors++;
    if (full_viol != 0) begin
      miscompares++; $display("FAIL latency_full_read: reads at limit=%0d, required 0", full_viol);
    end
  endtask

  task automatic test_len_zero();
    do_reset();
    spur_req++;
    repeat (4) @(negedge clk);
    #1;
    vectors++;
    if (err_count !== 16'h0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_spurious: err=%0d busy=%b, required 0/0", err_count, busy);
    end
    start_run(24'h500, 24'd0);
    @(negedge clk); #1;
    vectors++;
    if (done !== 1'b1 || pass !== 1'b1 || err_count !== 16'h0) begin
      miscompares++; $display("FAIL len0_result: done=%b pass=%b err=%0d, required 1/1/0", done, pass, err_count);
    end
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (rw_seen != 0 || done !== 1'b1) begin
      miscompares++; $display("FAIL len0_bus: commands=%0d done=%b, required 0/1", rw_seen, done);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    lat = 10;
    start_run(24'h200, 24'd8);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (out_mon == 3) ok = 1;
    end
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL mid_reach3: outstanding=%0d, required 3", out_mon);
    end
    @(negedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (avm_read !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset: rd=%b busy=%b done=%b, required 0/0/0", avm_read, busy, done);
    end
    @(negedge clk); #1;
    reset = 1'b0; lat = 3;
    start_run(24'h000, 24'd4);
    wait_done(ok);
    vectors++;
    if (!ok || pass !== 1'b1 || err_count !== 16'h0 || exp_wr.size() != 0) begin
      miscompares++; $display("FAIL mid_rerun: done=%b pass=%b err=%0d pending=%0d, required 1/1/0/0", ok, pass, err_count, exp_wr.size());
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0;
    test_reset();
    test_basic();
    test_waitrequest();
    test_corrupt();
    test_latency();
    test_len_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
